// File: rtl/hms_pkg.sv
// Shared types and helpers for the time-of-day / alarm core.
//   hms_t     : packed {hour, min, sec} used for the live time and alarm registers
//   hms_valid : range check of a time value against a configurable last hour
package hms_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MS_W   = 6;

  localparam logic [MS_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MS_W-1:0] MIN_MAX = 6'd59;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MS_W-1:0]   min;
    logic [MS_W-1:0]   sec;
  } hms_t;

  function automatic logic hms_valid(input hms_t t, input logic [HOUR_W-1:0] hour_max);
    return (t.hour <= hour_max) && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
  endfunction

endpackage

// File: rtl/hms_wrap_cnt.sv
// Wrapping counter 0..MAX with synchronous load (load has priority over count).
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance by one (wraps MAX -> 0)
//   load       : load load_val
//   value      : current count
//   carry      : en & (value == MAX), i.e. this advance wraps
module hms_wrap_cnt #(
  parameter int unsigned    W   = 6,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         carry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en) begin
      value <= (value == MAX) ? '0 : value + W'(1);
    end
  end

  assign carry = en & (value == MAX);

endmodule

// File: rtl/hms_alarm_core.sv
// Single-clock hours/minutes/seconds core with NUM_ALARM alarm channels.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_run             : prescaler counts when 1, time frozen when 0
//   i_wr_en/i_wr_tgt  : write strobe; target 0 = time, k = alarm channel k-1
//   i_wr_hour/min/sec : write value
//   i_alarm_en/clr    : per-channel arm / clear pulse
//   o_hour/min/sec    : current time
//   o_tick            : pulse on each seconds increment
//   o_day_wrap        : pulse when time wraps HOUR_MAX:59:59 -> 0:00:00
//   o_alarm           : latched alarm flags
//   o_wr_err          : pulse after a rejected write
module hms_alarm_core
  import hms_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned NUM_ALARM = 2,
  parameter int unsigned HOUR_MAX  = 23,
  parameter int unsigned ALARM_SEC = 60
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_run,
  input  logic                 i_wr_en,
  input  logic [2:0]           i_wr_tgt,
  input  logic [HOUR_W-1:0]    i_wr_hour,
  input  logic [MS_W-1:0]      i_wr_min,
  input  logic [MS_W-1:0]      i_wr_sec,
  input  logic [NUM_ALARM-1:0] i_alarm_en,
  input  logic [NUM_ALARM-1:0] i_alarm_clr,
  output logic [HOUR_W-1:0]    o_hour,
  output logic [MS_W-1:0]      o_min,
  output logic [MS_W-1:0]      o_sec,
  output logic                 o_tick,
  output logic                 o_day_wrap,
  output logic [NUM_ALARM-1:0] o_alarm,
  output logic                 o_wr_err
);

  localparam int unsigned       PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]     PRE_LAST  = PW'(CLK_HZ - 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX);
  localparam logic [2:0]        TGT_LAST  = 3'(NUM_ALARM);
  localparam int unsigned       CW        = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;
  localparam logic [CW-1:0]     TO_LOAD   = CW'(ALARM_SEC);

  logic [PW-1:0]        presc;
  hms_t                 wr;
  hms_t                 now;
  logic                 wr_ok;
  logic                 time_wr;
  logic                 tick;
  logic                 sec_c;
  logic                 min_c;
  logic                 hour_c;
  hms_t                 alarm_q [NUM_ALARM];
  logic [CW-1:0]        to_cnt  [NUM_ALARM];
  logic [NUM_ALARM-1:0] hit;

  assign wr      = '{hour: i_wr_hour, min: i_wr_min, sec: i_wr_sec};
  assign now     = '{hour: o_hour, min: o_min, sec: o_sec};
  assign wr_ok   = hms_valid(wr, HOUR_LAST) && (i_wr_tgt <= TGT_LAST);
  assign time_wr = i_wr_en && wr_ok && (i_wr_tgt == '0);
  // A time write on the same edge as a prescaler wrap swallows that tick.
  assign tick    = i_run && (presc == PRE_LAST) && !time_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (time_wr) begin
      presc <= '0;
    end else if (i_run) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
    end
  end

  hms_wrap_cnt #(.W(MS_W), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .en(tick), .load(time_wr),
    .load_val(wr.sec), .value(o_sec), .carry(sec_c)
  );

  hms_wrap_cnt #(.W(MS_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .en(sec_c), .load(time_wr),
    .load_val(wr.min), .value(o_min), .carry(min_c)
  );

  hms_wrap_cnt #(.W(HOUR_W), .MAX(HOUR_LAST)) u_hour (
    .clk(clk), .rst_n(rst_n), .en(min_c), .load(time_wr),
    .load_val(wr.hour), .value(o_hour), .carry(hour_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tick     <= 1'b0;
      o_day_wrap <= 1'b0;
      o_wr_err   <= 1'b0;
    end else begin
      o_tick     <= tick;
      o_day_wrap <= hour_c;
      o_wr_err   <= i_wr_en && !wr_ok;
    end
  end

  // o_tick marks the one cycle in which the time was just advanced by a tick,
  // so matching only then excludes times that arrived through a write.
  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < NUM_ALARM; k++) begin
      hit[k] = i_alarm_en[k] && o_tick && (now == alarm_q[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_ALARM; k++) begin
        alarm_q[k] <= '0;
        to_cnt[k]  <= '0;
      end
      o_alarm <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_ALARM; k++) begin
        if (i_wr_en && wr_ok && (i_wr_tgt == 3'(k + 1))) begin
          alarm_q[k] <= wr;
        end
        if (hit[k]) begin
          o_alarm[k] <= 1'b1;
          to_cnt[k]  <= TO_LOAD;
        end else if (!i_alarm_en[k] || i_alarm_clr[k]) begin
          o_alarm[k] <= 1'b0;
        end else if ((ALARM_SEC != 0) && o_alarm[k] && tick) begin
          to_cnt[k] <= to_cnt[k] - CW'(1);
          if (to_cnt[k] == CW'(1)) begin
            o_alarm[k] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
